// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg - shared definitions for the HI/LO multiply/divide unit.
//   * Operation codes carried on i_op.
//   * FSM state encoding for the iterative sequencer.
//   * Iteration counter width helper.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Counter must hold 0..WIDTH-1 with headroom for a full WIDTH count.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix - conditional two's-complement negate.
// Used on entry to turn signed operands into magnitudes and on exit to
// re-apply the result sign.
//   val : input value
//   neg : 1 = negate, 0 = pass through
//   res : conditioned value
// -----------------------------------------------------------------------------
module mdu_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] val,
    input  logic         neg,
    output logic [N-1:0] res
);

    assign res = neg ? (~val + N'(1)) : val;

endmodule

// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo - iterative multiply/divide unit with architectural HI/LO.
// Executes MULT, MULTU, DIV, DIVU (WIDTH shift-add / restoring-subtract
// steps) and single-cycle MTHI/MTLO. HI/LO change only on a result write or
// an MT write.
//
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-high reset
//   i_start issue pulse, sampled only while o_busy = 0
//   i_op    operation code (mdu_pkg::OP_*)
//   i_dat0  rs operand (multiplicand / dividend / MT source)
//   i_dat1  rt operand (multiplier / divisor)
//   o_busy  operation in flight
//   o_done  one-cycle pulse, HI/LO updated this cycle
//   o_hi    HI register
//   o_lo    LO register
//
// Build option: define MDU_FAST_MUL_EN to compute MULT/MULTU with a
// combinational multiplier (result written one edge after issue).
// -----------------------------------------------------------------------------
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_dat0,
    input  logic [WIDTH-1:0] i_dat1,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int            CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mdu_state_e         state_r;
    mdu_state_e         state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    // Working registers: acc_hi_r/acc_lo_r hold partial product or
    // remainder/quotient, opb_r holds the multiplicand/divisor magnitude.
    logic [WIDTH-1:0]   acc_hi_r;
    logic [WIDTH-1:0]   acc_lo_r;
    logic [WIDTH-1:0]   opb_r;
    logic               is_mul_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               div_zero_r;

    logic               load_s;
    logic               step_s;
    logic               res_wr_s;
    logic               mthi_s;
    logic               mtlo_s;
    logic               done_s;

    logic               is_signed_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] prod_raw_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

`ifdef MDU_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
    assign prod_raw_s = {{WIDTH{1'b0}}, acc_lo_r} * {{WIDTH{1'b0}}, opb_r};
`else
    localparam logic FAST_MUL = 1'b0;
    assign prod_raw_s = {acc_hi_r, acc_lo_r};
`endif

    assign is_signed_s = (i_op == OP_MULT) || (i_op == OP_DIV);

    // Operand magnitudes; unsigned ops pass straight through.
    mdu_sign_fix #(.N(WIDTH)) u_fix_a (
        .val (i_dat0),
        .neg (is_signed_s & i_dat0[WIDTH-1]),
        .res (mag_a_s)
    );

    mdu_sign_fix #(.N(WIDTH)) u_fix_b (
        .val (i_dat1),
        .neg (is_signed_s & i_dat1[WIDTH-1]),
        .res (mag_b_s)
    );

    // Result sign: product/quotient negate on differing signs, remainder
    // follows the dividend.
    mdu_sign_fix #(.N(2*WIDTH)) u_fix_prod (
        .val (prod_raw_s),
        .neg (neg_q_r),
        .res (prod_fix_s)
    );

    mdu_sign_fix #(.N(WIDTH)) u_fix_quo (
        .val (acc_lo_r),
        .neg (neg_q_r),
        .res (quo_fix_s)
    );

    mdu_sign_fix #(.N(WIDTH)) u_fix_rem (
        .val (acc_hi_r),
        .neg (neg_r_r),
        .res (rem_fix_s)
    );

    // Single-step arithmetic for the shift-add and restoring-divide paths.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, opb_r};
    end

    // Final HI/LO selection; a zero divisor forces LO to all ones while the
    // remainder path already reproduces the dividend.
    always_comb begin
        res_hi_s = rem_fix_s;
        res_lo_s = quo_fix_s;
        if (is_mul_r) begin
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end else if (div_zero_r) begin
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            res_lo_s = quo_fix_s;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        res_wr_s    = 1'b0;
        mthi_s      = 1'b0;
        mtlo_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    case (i_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            load_s      = 1'b1;
                            state_nxt_s = CALC;
                        end
                        OP_MTHI: begin
                            mthi_s = 1'b1;
                            done_s = 1'b1;
                        end
                        OP_MTLO: begin
                            mtlo_s = 1'b1;
                            done_s = 1'b1;
                        end
                        default: begin
                            state_nxt_s = IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (FAST_MUL && is_mul_r) begin
                    res_wr_s    = 1'b1;
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == LAST_STEP) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
            end
            FIX: begin
                res_wr_s    = 1'b1;
                done_s      = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch and per-step datapath update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r      <= {CW{1'b0}};
            acc_hi_r   <= {WIDTH{1'b0}};
            acc_lo_r   <= {WIDTH{1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            is_mul_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (load_s) begin
            cnt_r      <= {CW{1'b0}};
            acc_hi_r   <= {WIDTH{1'b0}};
            acc_lo_r   <= mag_a_s;
            opb_r      <= mag_b_s;
            is_mul_r   <= ~i_op[1];
            neg_q_r    <= is_signed_s & (i_dat0[WIDTH-1] ^ i_dat1[WIDTH-1]);
            neg_r_r    <= is_signed_s & i_dat0[WIDTH-1];
            div_zero_r <= (i_dat1 == {WIDTH{1'b0}});
        end else if (step_s) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (is_mul_r) begin
                acc_hi_r <= mul_sum_s[WIDTH:1];
                acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
            end else if (!div_trial_s[WIDTH]) begin
                acc_hi_r <= div_trial_s[WIDTH-1:0];
                acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_r <= div_shift_s[WIDTH-1:0];
                acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Architectural HI/LO: written only by a result or an MT operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (res_wr_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (mthi_s) begin
            hi_r <= i_dat0;
        end else if (mtlo_s) begin
            lo_r <= i_dat0;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= done_s;
        end
    end

    assign o_busy = busy_r;
    assign o_done = done_r;
    assign o_hi   = hi_r;
    assign o_lo   = lo_r;

endmodule

// File: tb/tb_mdu_hilo.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo - self-checking bench for mdu_hilo (WIDTH = 32).
// Expected {HI,LO} and latency are queued when an operation is issued and
// compared when o_done pulses. Latency counts clock edges from the issue
// edge (inclusive) to the edge after which o_done is high.
// -----------------------------------------------------------------------------
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [2:0]   i_op = 3'd0;
    logic [W-1:0] i_dat0 = '0;
    logic [W-1:0] i_dat1 = '0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;

    int n_checks = 0;
    int n_errors = 0;
    int lat_cnt  = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];
    logic [63:0] cur_hilo = 64'd0;

    mdu_hilo #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_dat0  (i_dat0),
        .i_dat1  (i_dat1),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
        lat_cnt++;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (op)
            OP_MULTU: res = {32'd0, a} * {32'd0, b};
            OP_MULT:  res = sa * sb;
            OP_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            OP_DIV: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Drive an issue for one edge (the issue edge).
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_dat0  = a;
        i_dat1  = b;
        lat_cnt = 0;
        tick();
        i_start = 1'b0;
    endtask

    // Wait (bounded) for o_done, then pop and compare the scoreboard entry.
    task automatic wait_done();
        logic [63:0] exp;
        int          lat;
        int          guard;
        guard = 0;
        while (!o_done && guard < 100) begin
            tick();
            guard++;
        end
        exp = exp_q.pop_front();
        lat = lat_q.pop_front();
        if (!o_done) begin
            check_eq("done_timeout", 64'(o_done), 64'd1);
        end else begin
            check_eq("hilo", {o_hi, o_lo}, exp);
            check_eq("latency", 64'(lat_cnt), 64'(lat));
        end
        cur_hilo = exp;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input logic exp_busy);
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        start_op(op, a, b);
        check_eq("busy_after_issue", 64'(o_busy), 64'(exp_busy));
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_hilo", {o_hi, o_lo}, 64'd0);
        check_eq("rst_busy_done", {62'd0, o_busy, o_done}, 64'd0);
        #2 i_rst = 1'b0;
        tick();

        // Arithmetic vectors; issued back to back in the o_done cycle.
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT, 1'b1);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, 1'b1);
        run_op(OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, DIV_LAT, 1'b1);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT, 1'b1);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DIV_LAT, 1'b1);
        run_op(OP_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, DIV_LAT, 1'b1);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_LAT, 1'b1);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MUL_LAT, 1'b1);

        // MTHI / MTLO: single cycle, never busy.
        run_op(OP_MTHI, 32'h0000_1234, 32'd0, 64'h0000_1234_0000_0000, 1, 1'b0);
        run_op(OP_MTLO, 32'h0000_ABCD, 32'd0, 64'h0000_1234_0000_ABCD, 1, 1'b0);

        // Start while busy is ignored; HI/LO hold during the operation.
        exp_q.push_back(64'h0000_0000_0000_002A);
`ifdef MDU_FAST_MUL_EN
        lat_q.push_back(DIV_LAT);
        start_op(OP_DIVU, 32'd84, 32'd2);
`else
        lat_q.push_back(MUL_LAT);
        start_op(OP_MULTU, 32'd6, 32'd7);
`endif
        repeat (10) tick();
        check_eq("hilo_stable_busy", {o_hi, o_lo}, cur_hilo);
        i_start = 1'b1;
        i_op    = OP_DIVU;
        i_dat0  = 32'd9;
        i_dat1  = 32'd3;
        tick();
        i_start = 1'b0;
        check_eq("busy_during_intruder", 64'(o_busy), 64'd1);
        wait_done();

        // Reserved op code: no busy, no done, HI/LO unchanged.
        start_op(3'd6, 32'hDEAD_BEEF, 32'd1);
        check_eq("rsvd_busy_done", {62'd0, o_busy, o_done}, 64'd0);
        tick();
        check_eq("rsvd_hilo", {o_hi, o_lo}, cur_hilo);

        // Asynchronous reset in the middle of a divide.
        start_op(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        repeat (9) tick();
        #2 i_rst = 1'b1;
        #1;
        check_eq("async_rst_hilo", {o_hi, o_lo}, 64'd0);
        check_eq("async_rst_busy_done", {62'd0, o_busy, o_done}, 64'd0);
        #1 i_rst = 1'b0;
        cur_hilo = 64'd0;
        tick();
        check_eq("post_rst_busy", 64'(o_busy), 64'd0);
        run_op(OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DIV_LAT, 1'b1);
        run_op(OP_MULTU, 32'd6, 32'd7, 64'h0000_0000_0000_002A, MUL_LAT, 1'b1);

        // Random iterative operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(op, a, b, model(op, a, b), (op[1] == 1'b0) ? MUL_LAT : DIV_LAT, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
